// File: rtl/dino_pkg.sv
// Constants and FSM encoding shared by the dino motion controller and the VGA renderer.
package dino_pkg;

  localparam int GROUND_Y = 275;
  localparam int DINO_X   = 50;

  typedef enum logic [1:0] {
    ST_GROUND = 2'd0,
    ST_DUCK   = 2'd1,
    ST_RISE   = 2'd2,
    ST_FALL   = 2'd3
  } dino_state_t;

  function automatic logic isAirborne(input dino_state_t st);
    return (st == ST_RISE) || (st == ST_FALL);
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchronizer followed by a stability counter; the output level only
// follows the synchronized input once it has disagreed for DEBOUNCE_CYCLES cycles.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic level_o
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LastCount = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q;
  logic [CW-1:0] count_q;

  // Any cycle where the input agrees with the held level restarts the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      count_q <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      if (sync2_q != level_q) begin
        if (count_q == LastCount) begin
          level_q <= sync2_q;
          count_q <= '0;
        end else begin
          count_q <= count_q + CW'(1);
        end
      end else begin
        count_q <= '0;
      end
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/dino_motion_ctrl.sv
// Dino jump/duck motion controller: debounced buttons drive a ballistic FSM that
// advances once per VGA frame and freezes while the game is over.
module dino_motion_ctrl #(
  parameter int GROUND_Y        = dino_pkg::GROUND_Y,
  parameter int DINO_X          = dino_pkg::DINO_X,
  parameter int JUMP_V0         = 20,
  parameter int GRAVITY         = 1,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        up_btn,
  input  logic        down_btn,
  input  logic        screen_end,
  input  logic        game_over,
  output logic        up,
  output logic        down,
  output logic [31:0] dino_x,
  output logic [31:0] dino_y,
  output logic        airborne,
  output logic [15:0] jump_count
);

  import dino_pkg::*;

  localparam logic [31:0] GroundY = 32'(GROUND_Y);
  localparam logic [4:0]  Grav5   = 5'(GRAVITY);
  localparam logic [4:0]  V0      = 5'(JUMP_V0);

  dino_state_t state_q, state_d;
  logic [4:0]  vel_q, vel_d;
  logic [31:0] dinoY_q, dinoY_d;
  logic [15:0] jumpCount_q, jumpCount_d;
  logic        airborne_q, airborne_d;
  logic        screenEnd_q;
  logic        frameTick;
  logic        upLevel, downLevel;
  logic [4:0]  velMinusG;
  logic [31:0] fallSum;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) upDebounce (
    .clk     (clk),
    .reset   (reset),
    .btn_i   (up_btn),
    .level_o (upLevel)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) downDebounce (
    .clk     (clk),
    .reset   (reset),
    .btn_i   (down_btn),
    .level_o (downLevel)
  );

  assign frameTick = screen_end & ~screenEnd_q;
  assign velMinusG = vel_q - Grav5;
  assign fallSum   = dinoY_q + 32'(vel_q) + 32'(GRAVITY);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_GROUND;
      vel_q       <= '0;
      dinoY_q     <= GroundY;
      jumpCount_q <= '0;
      airborne_q  <= 1'b0;
      screenEnd_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      vel_q       <= vel_d;
      dinoY_q     <= dinoY_d;
      jumpCount_q <= jumpCount_d;
      airborne_q  <= airborne_d;
      screenEnd_q <= screen_end;
    end
  end

  // Motion only advances on the rising edge of screen_end; jump has priority over duck.
  always_comb begin
    state_d     = state_q;
    vel_d       = vel_q;
    dinoY_d     = dinoY_q;
    jumpCount_d = jumpCount_q;
    if (frameTick && !game_over) begin
      case (state_q)
        ST_GROUND, ST_DUCK: begin
          if (upLevel) begin
            state_d = ST_RISE;
            vel_d   = V0;
            if (jumpCount_q != 16'hFFFF) jumpCount_d = jumpCount_q + 16'd1;
          end else if (downLevel) begin
            state_d = ST_DUCK;
          end else begin
            state_d = ST_GROUND;
          end
        end
        ST_RISE: begin
          if (downLevel) begin
            state_d = ST_FALL;
            vel_d   = '0;
          end else begin
            dinoY_d = dinoY_q - 32'(vel_q);
            vel_d   = velMinusG;
            if (velMinusG == 5'd0) state_d = ST_FALL;
          end
        end
        ST_FALL: begin
          if (fallSum >= GroundY) begin
            dinoY_d = GroundY;
            vel_d   = '0;
            state_d = ST_GROUND;
          end else begin
            dinoY_d = fallSum;
            vel_d   = vel_q + Grav5;
          end
        end
        default: state_d = ST_GROUND;
      endcase
    end
  end

  always_comb begin
    airborne_d = isAirborne(state_d);
  end

  assign up         = upLevel;
  assign down       = downLevel;
  assign dino_x     = 32'(DINO_X);
  assign dino_y     = dinoY_q;
  assign airborne   = airborne_q;
  assign jump_count = jumpCount_q;

endmodule

// File: tb/tb_dino_motion_ctrl.sv
// Self-checking bench for dino_motion_ctrl: a per-cycle behavioural model plus
// directed jump, fast-fall, duck, debounce-glitch, game-over and reset scenarios.
module tb_dino_motion_ctrl;

  localparam int GY = 275;
  localparam int DX = 50;
  localparam int V0 = 20;
  localparam int G  = 1;
  localparam int DB = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        upBtn, downBtn, screenEnd, gameOver;
  logic        up, down, airborne;
  logic [31:0] dinoX, dinoY;
  logic [15:0] jumpCount;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dino_motion_ctrl #(
    .GROUND_Y(GY), .DINO_X(DX), .JUMP_V0(V0), .GRAVITY(G), .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .up_btn     (upBtn),
    .down_btn   (downBtn),
    .screen_end (screenEnd),
    .game_over  (gameOver),
    .up         (up),
    .down       (down),
    .dino_x     (dinoX),
    .dino_y     (dinoY),
    .airborne   (airborne),
    .jump_count (jumpCount)
  );

  typedef enum {M_GROUND, M_DUCK, M_RISE, M_FALL} mode_t;
  mode_t mMode;
  int    mY, mVel, mJumps;
  bit    mUp, mDown, mSePrev;
  bit    upHist[$];
  bit    downHist[$];

  // A raw sample reaches the debouncer two edges late; the level flips once the
  // last DB synchronized samples all disagree with it.
  function automatic bit windowDiffers(input bit hist[$], input bit level);
    int n = hist.size();
    for (int i = n - DB - 2; i <= n - 3; i++)
      if (hist[i] == level) return 1'b0;
    return 1'b1;
  endfunction

  task automatic stepMotion();
    case (mMode)
      M_GROUND, M_DUCK: begin
        if (mUp) begin
          mMode = M_RISE;
          mVel  = V0;
          if (mJumps < 65535) mJumps++;
        end else begin
          mMode = mDown ? M_DUCK : M_GROUND;
        end
      end
      M_RISE: begin
        if (mDown) begin
          mMode = M_FALL;
          mVel  = 0;
        end else begin
          mY   = mY - mVel;
          mVel = mVel - G;
          if (mVel == 0) mMode = M_FALL;
        end
      end
      M_FALL: begin
        if (mY + mVel + G >= GY) begin
          mY    = GY;
          mVel  = 0;
          mMode = M_GROUND;
        end else begin
          mVel = mVel + G;
          mY   = mY + mVel;
        end
      end
      default: mMode = M_GROUND;
    endcase
  endtask

  always @(posedge clk or posedge reset) begin
    bit frameTick;
    if (reset) begin
      mMode = M_GROUND; mY = GY; mVel = 0; mJumps = 0;
      mUp = 1'b0; mDown = 1'b0; mSePrev = 1'b0;
      upHist.delete();
      downHist.delete();
      for (int i = 0; i < DB + 2; i++) begin
        upHist.push_back(1'b0);
        downHist.push_back(1'b0);
      end
    end else begin
      frameTick = screenEnd && !mSePrev;
      mSePrev   = screenEnd;
      if (frameTick && !gameOver) stepMotion();
      upHist.push_back(upBtn);
      downHist.push_back(downBtn);
      if (windowDiffers(upHist, mUp)) mUp = !mUp;
      if (windowDiffers(downHist, mDown)) mDown = !mDown;
      void'(upHist.pop_front());
      void'(downHist.pop_front());
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      checkOutput("modelUp", {31'b0, up}, {31'b0, mUp});
      checkOutput("modelDown", {31'b0, down}, {31'b0, mDown});
      checkOutput("modelDinoX", dinoX, DX);
      checkOutput("modelDinoY", dinoY, 32'(mY));
      checkOutput("modelAirborne", {31'b0, airborne},
                  {31'b0, (mMode == M_RISE) || (mMode == M_FALL)});
      checkOutput("modelJumpCount", {16'b0, jumpCount}, 32'(mJumps));
    end
  end

  task automatic applyStimulus(input logic u, input logic d, input logic go);
    upBtn    = u;
    downBtn  = d;
    gameOver = go;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) screenEnd = 1'b1;
      @(negedge clk) screenEnd = 1'b0;
    end
  endtask

  task automatic waitLevel(input bit isDown, input logic val);
    int n = 0;
    while (((isDown ? down : up) !== val) && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput(isDown ? "downSettle" : "upSettle",
                {31'b0, isDown ? down : up}, {31'b0, val});
  endtask

  initial begin
    reset = 1'b0;
    screenEnd = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    checkOutput("resetDinoY", dinoY, 275);
    checkOutput("resetDinoX", dinoX, 50);
    checkOutput("resetJumpCount", {16'b0, jumpCount}, 0);
    checkOutput("resetAirborne", {31'b0, airborne}, 0);
    checkOutput("resetUp", {31'b0, up}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Full jump: peak after 20 rising ticks, landing after 20 falling ticks.
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitLevel(1'b0, 1'b1);
    tick(1);
    checkOutput("jumpStartY", dinoY, 275);
    checkOutput("jumpStartAir", {31'b0, airborne}, 1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick(20);
    checkOutput("peakY", dinoY, 65);
    checkOutput("peakAir", {31'b0, airborne}, 1);
    tick(20);
    checkOutput("landY", dinoY, 275);
    checkOutput("landAir", {31'b0, airborne}, 0);
    checkOutput("landCount", {16'b0, jumpCount}, 1);

    // Fast fall from 185: 185 + k(k+1)/2 first reaches 275 at k = 13.
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitLevel(1'b0, 1'b1);
    tick(1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick(5);
    checkOutput("riseFiveY", dinoY, 185);
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitLevel(1'b1, 1'b1);
    tick(1);
    checkOutput("fastFallStartY", dinoY, 185);
    checkOutput("fastFallAir", {31'b0, airborne}, 1);
    tick(12);
    checkOutput("fastFallMidY", dinoY, 263);
    tick(1);
    checkOutput("fastFallLandY", dinoY, 275);
    checkOutput("fastFallLandAir", {31'b0, airborne}, 0);
    checkOutput("fastFallCount", {16'b0, jumpCount}, 2);

    // Duck, then both buttons: jump wins.
    tick(1);
    checkOutput("duckY", dinoY, 275);
    checkOutput("duckAir", {31'b0, airborne}, 0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    waitLevel(1'b0, 1'b1);
    tick(1);
    checkOutput("bothAir", {31'b0, airborne}, 1);
    checkOutput("bothCount", {16'b0, jumpCount}, 3);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitLevel(1'b1, 1'b0);
    tick(1);
    checkOutput("bothRiseY", dinoY, 255);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitLevel(1'b0, 1'b0);
    tick(45);
    checkOutput("bothLandY", dinoY, 275);

    // Debounce: a 3-cycle glitch is ignored, a 6-cycle pulse is accepted.
    upBtn = 1'b1;
    repeat (3) @(negedge clk);
    upBtn = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("glitchUp", {31'b0, up}, 0);
    tick(1);
    checkOutput("glitchAir", {31'b0, airborne}, 0);
    checkOutput("glitchCount", {16'b0, jumpCount}, 3);
    upBtn = 1'b1;
    repeat (6) @(negedge clk);
    upBtn = 1'b0;
    checkOutput("pulseUp", {31'b0, up}, 1);
    tick(1);
    checkOutput("pulseAir", {31'b0, airborne}, 1);
    checkOutput("pulseCount", {16'b0, jumpCount}, 4);
    tick(45);
    checkOutput("pulseLandY", dinoY, 275);

    // Freeze mid-air at 275 - (20+19+18+17+16+15) = 170, then async reset.
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitLevel(1'b0, 1'b1);
    tick(1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick(6);
    checkOutput("preFreezeY", dinoY, 170);
    applyStimulus(1'b0, 1'b0, 1'b1);
    tick(10);
    checkOutput("frozenY", dinoY, 170);
    checkOutput("frozenAir", {31'b0, airborne}, 1);
    checkOutput("frozenCount", {16'b0, jumpCount}, 5);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("asyncResetY", dinoY, 275);
    checkOutput("asyncResetCount", {16'b0, jumpCount}, 0);
    checkOutput("asyncResetAir", {31'b0, airborne}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
